// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder for the fetch interface
// Single-outstanding fetch with programmable wait states and a program-load write port.
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  WAIT_INIT = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        enter_resp;
    logic [31:0] fetch_addr;
    logic        fetch_misaligned;
    logic        fetch_out_of_range;
    logic [31:0] fetch_word;
    logic        ld_in_range;
    logic        unused_ld_lsbs;

    assign unused_ld_lsbs = ^ld_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the read happens on the accept edge, before addr_q holds the address.
    always_comb begin
        enter_resp         = (state_q != S_RESP) && (state_d == S_RESP);
        fetch_addr         = (state_q == S_IDLE) ? req_addr : addr_q;
        fetch_misaligned   = |fetch_addr[1:0];
        fetch_out_of_range = |fetch_addr[31:AW+2];
        fetch_word         = mem[fetch_addr[AW+1:2]];
        rsp_data_d         = rsp_data_q;
        rsp_err_d          = rsp_err_q;
        if (enter_resp) begin
            if (fetch_misaligned || fetch_out_of_range) begin
                rsp_data_d = NOP_WORD;
                rsp_err_d  = 1'b1;
            end else begin
                rsp_data_d = fetch_word;
                rsp_err_d  = 1'b0;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
    end

    assign ld_in_range = ~|ld_addr[31:AW+2];

    // Memory keeps its contents through reset; the reset branch only blocks loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (ld_en && ld_in_range) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
    end
endmodule
